spi_cfg_bank: RTL and testbench

- Parametrised SPI-frame-to-register-bank bridge.
- Parses byte frames from the SPI slave RX stream into an address header plus one or more data words.
- Writes matching configuration channels, or returns read data on the SPI TX stream.
- Adds to the previous generation: configurable address/data widths, multi-word burst with address auto-increment, configurable read latency, and address-miss reporting.

---
 rtl/spi_cfg_bank.sv | 219 +++++++++++++++++++++
 tb/tb_spi_cfg_bank.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_bank.sv
// SPI-frame-to-register-bank bridge: parses header + data words from the SPI RX
// byte stream, writes matching configuration channels, or streams readback on TX.
module spi_cfg_bank #(
    parameter int                    NUM          = 32,
    parameter int                    ASIZE        = 15,
    parameter int                    DSIZE        = 16,
    parameter int                    RD_LAT       = 2,
    parameter int                    BURST        = 1,
    parameter logic [NUM*DSIZE-1:0]  DEFAULT_DATA = '0
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   rx_stream_sof,
    input  logic [7:0]             rx_stream_data,
    input  logic                   rx_stream_vld,
    input  logic                   rx_stream_eof,
    input  logic                   tx_empty,
    output logic [23:0]            tx_send_momment,
    output logic [7:0]             tx_send_data,
    output logic                   tx_send_valid,
    input  logic [NUM*ASIZE-1:0]   cfg_addr_map,
    input  logic [NUM*DSIZE-1:0]   cfg_rdata,
    output logic [NUM*DSIZE-1:0]   cfg_wdata,
    output logic [NUM-1:0]         cfg_wr_en,
    output logic                   addr_err
);

    localparam int ABYTES = (ASIZE + 8) / 8;
    localparam int DBYTES = (DSIZE + 7) / 8;
    localparam int HW     = 8 * ABYTES;
    localparam int WW     = 8 * DBYTES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_WCOMMIT,
        S_RLAT,
        S_RDATA,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [HW-1:0]          hdr_q;
    logic [WW-1:0]          word_q;
    logic [WW-1:0]          shift_q;
    logic [ASIZE-1:0]       addr_q;
    logic [7:0]             byte_cnt_q;
    logic [3:0]             lat_cnt_q;
    logic [NUM*DSIZE-1:0]   cfg_wdata_q;
    logic [NUM-1:0]         cfg_wr_en_q;
    logic [7:0]             tx_data_q;
    logic                   tx_valid_q;
    logic                   addr_err_q;

    logic [HW-1:0]          hdr_d;
    logic [WW-1:0]          word_d;
    logic                   hit;
    logic [NUM-1:0]         hit_oh;
    logic [DSIZE-1:0]       rd_sel;

    assign tx_send_momment = 24'd1;
    assign tx_send_data    = tx_data_q;
    assign tx_send_valid   = tx_valid_q;
    assign cfg_wdata       = cfg_wdata_q;
    assign cfg_wr_en       = cfg_wr_en_q;
    assign addr_err        = addr_err_q;

    // MSB-first byte shifters: the truncating cast drops the oldest byte.
    always_comb begin
        hdr_d  = HW'({hdr_q, rx_stream_data});
        word_d = WW'({word_q, rx_stream_data});
    end

    // Address match against the channel map; the first (lowest) matching channel wins.
    always_comb begin
        hit    = 1'b0;
        hit_oh = '0;
        rd_sel = '0;
        for (int unsigned k = 0; k < NUM; k++) begin
            if (!hit && (addr_q == cfg_addr_map[k*ASIZE +: ASIZE])) begin
                hit       = 1'b1;
                hit_oh[k] = 1'b1;
                rd_sel    = cfg_rdata[k*DSIZE +: DSIZE];
            end
        end
    end

    // Frame parser FSM with registered strobes, channel registers and TX byte output.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hdr_q       <= '0;
            word_q      <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            byte_cnt_q  <= '0;
            lat_cnt_q   <= '0;
            cfg_wdata_q <= DEFAULT_DATA;
            cfg_wr_en_q <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            cfg_wr_en_q <= '0;
            tx_valid_q  <= 1'b0;
            addr_err_q  <= 1'b0;

            if (rx_stream_sof) begin
                state_q    <= S_ADDR;
                byte_cnt_q <= '0;
                hdr_q      <= '0;
                word_q     <= '0;
            end else if (rx_stream_eof) begin
                state_q    <= S_IDLE;
                byte_cnt_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                    end

                    S_ADDR: begin
                        if (rx_stream_vld) begin
                            hdr_q <= hdr_d;
                            if (byte_cnt_q == 8'(ABYTES - 1)) begin
                                byte_cnt_q <= '0;
                                addr_q     <= hdr_d[ASIZE-1:0];
                                word_q     <= '0;
                                lat_cnt_q  <= '0;
                                state_q    <= hdr_d[HW-1] ? S_WDATA : S_RLAT;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 8'd1;
                            end
                        end
                    end

                    S_WDATA: begin
                        if (rx_stream_vld) begin
                            word_q <= word_d;
                            if (byte_cnt_q == 8'(DBYTES - 1)) begin
                                byte_cnt_q <= '0;
                                state_q    <= S_WCOMMIT;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 8'd1;
                            end
                        end
                    end

                    S_WCOMMIT: begin
                        cfg_wr_en_q <= hit_oh;
                        addr_err_q  <= ~hit;
                        for (int unsigned k = 0; k < NUM; k++) begin
                            if (hit_oh[k]) begin
                                cfg_wdata_q[k*DSIZE +: DSIZE] <= word_q[DSIZE-1:0];
                            end
                        end
                        if (BURST != 0) begin
                            addr_q <= addr_q + ASIZE'(1);
                            // A byte arriving during commit is the first byte of the next word.
                            if (rx_stream_vld) begin
                                word_q <= word_d;
                                if (DBYTES == 1) begin
                                    byte_cnt_q <= '0;
                                    state_q    <= S_WCOMMIT;
                                end else begin
                                    byte_cnt_q <= 8'd1;
                                    state_q    <= S_WDATA;
                                end
                            end else begin
                                byte_cnt_q <= '0;
                                state_q    <= S_WDATA;
                            end
                        end else begin
                            state_q <= S_DONE;
                        end
                    end

                    S_RLAT: begin
                        if (lat_cnt_q == 4'(RD_LAT - 1)) begin
                            shift_q    <= WW'(rd_sel);
                            addr_err_q <= ~hit;
                            byte_cnt_q <= '0;
                            state_q    <= S_RDATA;
                        end else begin
                            lat_cnt_q <= lat_cnt_q + 4'd1;
                        end
                    end

                    S_RDATA: begin
                        // Holding off while tx_valid_q is set spaces strobes two clocks apart.
                        if (tx_empty && !tx_valid_q) begin
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= shift_q[WW-1 -: 8];
                            shift_q    <= WW'({shift_q, 8'h00});
                            if (byte_cnt_q == 8'(DBYTES - 1)) begin
                                byte_cnt_q <= '0;
                                if (BURST != 0) begin
                                    addr_q    <= addr_q + ASIZE'(1);
                                    lat_cnt_q <= '0;
                                    state_q   <= S_RLAT;
                                end else begin
                                    state_q <= S_DONE;
                                end
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 8'd1;
                            end
                        end
                    end

                    S_DONE: begin
                    end

                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cfg_bank.sv
// Directed self-checking bench for spi_cfg_bank with default parameters.
module tb_spi_cfg_bank;

    localparam int NUM   = 32;
    localparam int ASIZE = 15;
    localparam int DSIZE = 16;

    logic                  clock = 1'b0;
    logic                  rst = 1'b1;
    logic                  rx_stream_sof = 1'b0;
    logic [7:0]            rx_stream_data = 8'h00;
    logic                  rx_stream_vld = 1'b0;
    logic                  rx_stream_eof = 1'b0;
    logic                  tx_empty = 1'b1;
    logic [23:0]           tx_send_momment;
    logic [7:0]            tx_send_data;
    logic                  tx_send_valid;
    logic [NUM*ASIZE-1:0]  cfg_addr_map;
    logic [NUM*DSIZE-1:0]  cfg_rdata;
    logic [NUM*DSIZE-1:0]  cfg_wdata;
    logic [NUM-1:0]        cfg_wr_en;
    logic                  addr_err;

    spi_cfg_bank #(
        .NUM(NUM),
        .ASIZE(ASIZE),
        .DSIZE(DSIZE),
        .RD_LAT(2),
        .BURST(1),
        .DEFAULT_DATA('0)
    ) dut (
        .clock(clock),
        .rst(rst),
        .rx_stream_sof(rx_stream_sof),
        .rx_stream_data(rx_stream_data),
        .rx_stream_vld(rx_stream_vld),
        .rx_stream_eof(rx_stream_eof),
        .tx_empty(tx_empty),
        .tx_send_momment(tx_send_momment),
        .tx_send_data(tx_send_data),
        .tx_send_valid(tx_send_valid),
        .cfg_addr_map(cfg_addr_map),
        .cfg_rdata(cfg_rdata),
        .cfg_wdata(cfg_wdata),
        .cfg_wr_en(cfg_wr_en),
        .addr_err(addr_err)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int err_cnt = 0;
    logic [31:0] wr_log[$];
    logic [7:0]  tx_log[$];
    int          tx_cyc[$];
    logic [NUM*DSIZE-1:0] exp_wdata = '0;

    always @(posedge clock) cyc <= cyc + 1;

    // Event recorder: write strobes, TX strobes and miss pulses, sampled mid-cycle.
    always @(negedge clock) begin
        if (!rst) begin
            if (cfg_wr_en != '0) wr_log.push_back(cfg_wr_en);
            if (addr_err) err_cnt++;
            if (tx_send_valid) begin
                tx_log.push_back(tx_send_data);
                tx_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_logs();
        wr_log.delete();
        tx_log.delete();
        tx_cyc.delete();
        err_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_sof();
        rx_stream_sof = 1'b1;
        @(negedge clock);
        rx_stream_sof = 1'b0;
    endtask

    task automatic pulse_eof();
        rx_stream_eof = 1'b1;
        @(negedge clock);
        rx_stream_eof = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_stream_vld  = 1'b1;
        rx_stream_data = b;
        @(negedge clock);
        rx_stream_vld  = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int limit, output logic timed_out);
        for (int i = 0; i < limit; i++) begin
            if (tx_log.size() >= n) break;
            @(negedge clock);
            #1;
        end
        timed_out = (tx_log.size() < n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        vectors++; if (cfg_wdata !== '0) begin miscompares++; $display("FAIL reset_wdata got %h exp 0", cfg_wdata); end
        vectors++; if (cfg_wr_en !== '0) begin miscompares++; $display("FAIL reset_wr_en got %h exp 0", cfg_wr_en); end
        vectors++; if (tx_send_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid got %b exp 0", tx_send_valid); end
        vectors++; if (tx_send_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data got %h exp 00", tx_send_data); end
        vectors++; if (addr_err !== 1'b0) begin miscompares++; $display("FAIL reset_addr_err got %b exp 0", addr_err); end
        vectors++; if (tx_send_momment !== 24'd1) begin miscompares++; $display("FAIL momment got %h exp 1", tx_send_momment); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_write();
        logic [31:0] first;
        clear_logs();
        pulse_sof();
        send_byte(8'h80); send_byte(8'h12); send_byte(8'hAB); send_byte(8'hCD);
        idle(4);
        pulse_eof();
        idle(2);
        exp_wdata[3*DSIZE +: DSIZE] = 16'hABCD;
        first = (wr_log.size() > 0) ? wr_log[0] : 32'h0;
        vectors++; if (wr_log.size() != 1) begin miscompares++; $display("FAIL write_pulses got %0d exp 1", wr_log.size()); end
        vectors++; if (first !== 32'h0000_0008) begin miscompares++; $display("FAIL write_wr_en got %h exp 00000008", first); end
        vectors++; if (cfg_wdata !== exp_wdata) begin miscompares++; $display("FAIL write_wdata got %h exp %h", cfg_wdata, exp_wdata); end
        vectors++; if (err_cnt != 0) begin miscompares++; $display("FAIL write_err got %0d exp 0", err_cnt); end
    endtask

    task automatic test_read();
        logic to;
        logic [7:0] b0, b1;
        int gap;
        clear_logs();
        tx_empty = 1'b1;
        pulse_sof();
        send_byte(8'h01); send_byte(8'h00);
        wait_tx(2, 40, to);
        pulse_eof();
        idle(4);
        b0  = (tx_log.size() > 0) ? tx_log[0] : 8'hXX;
        b1  = (tx_log.size() > 1) ? tx_log[1] : 8'hXX;
        gap = (tx_cyc.size() > 1) ? tx_cyc[1] - tx_cyc[0] : 0;
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL read_timeout got %0d strobes exp 2", tx_log.size()); end
        vectors++; if (tx_log.size() != 2) begin miscompares++; $display("FAIL read_count got %0d exp 2", tx_log.size()); end
        vectors++; if (b0 !== 8'h12) begin miscompares++; $display("FAIL read_byte0 got %h exp 12", b0); end
        vectors++; if (b1 !== 8'h34) begin miscompares++; $display("FAIL read_byte1 got %h exp 34", b1); end
        vectors++; if (gap < 2) begin miscompares++; $display("FAIL read_gap got %0d exp >=2", gap); end
        vectors++; if (err_cnt != 0) begin miscompares++; $display("FAIL read_err got %0d exp 0", err_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w0, w1;
        clear_logs();
        pulse_sof();
        send_byte(8'h80); send_byte(8'h20);
        send_byte(8'h11); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h22);
        idle(4);
        pulse_eof();
        idle(2);
        exp_wdata[0*DSIZE +: DSIZE] = 16'h1111;
        exp_wdata[1*DSIZE +: DSIZE] = 16'h2222;
        w0 = (wr_log.size() > 0) ? wr_log[0] : 32'h0;
        w1 = (wr_log.size() > 1) ? wr_log[1] : 32'h0;
        vectors++; if (wr_log.size() != 2) begin miscompares++; $display("FAIL burst_pulses got %0d exp 2", wr_log.size()); end
        vectors++; if (w0 !== 32'h1) begin miscompares++; $display("FAIL burst_wr_en0 got %h exp 00000001", w0); end
        vectors++; if (w1 !== 32'h2) begin miscompares++; $display("FAIL burst_wr_en1 got %h exp 00000002", w1); end
        vectors++; if (cfg_wdata !== exp_wdata) begin miscompares++; $display("FAIL burst_wdata got %h exp %h", cfg_wdata, exp_wdata); end
        vectors++; if (err_cnt != 0) begin miscompares++; $display("FAIL burst_err got %0d exp 0", err_cnt); end
    endtask

    task automatic test_miss();
        logic to;
        logic [7:0] b0, b1;
        clear_logs();
        pulse_sof();
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hDE); send_byte(8'hAD);
        idle(4);
        pulse_eof();
        idle(2);
        vectors++; if (wr_log.size() != 0) begin miscompares++; $display("FAIL wmiss_pulses got %0d exp 0", wr_log.size()); end
        vectors++; if (err_cnt != 1) begin miscompares++; $display("FAIL wmiss_err got %0d exp 1", err_cnt); end
        vectors++; if (cfg_wdata !== exp_wdata) begin miscompares++; $display("FAIL wmiss_wdata got %h exp %h", cfg_wdata, exp_wdata); end

        clear_logs();
        pulse_sof();
        send_byte(8'h7F); send_byte(8'hFF);
        wait_tx(2, 40, to);
        pulse_eof();
        idle(4);
        b0 = (tx_log.size() > 0) ? tx_log[0] : 8'hXX;
        b1 = (tx_log.size() > 1) ? tx_log[1] : 8'hXX;
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL rmiss_timeout got %0d strobes exp 2", tx_log.size()); end
        vectors++; if (b0 !== 8'h00) begin miscompares++; $display("FAIL rmiss_byte0 got %h exp 00", b0); end
        vectors++; if (b1 !== 8'h00) begin miscompares++; $display("FAIL rmiss_byte1 got %h exp 00", b1); end
        vectors++; if (err_cnt != 1) begin miscompares++; $display("FAIL rmiss_err got %0d exp 1", err_cnt); end
    endtask

    task automatic test_wrap();
        logic [31:0] w0;
        clear_logs();
        pulse_sof();
        send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h03); send_byte(8'h04);
        idle(4);
        pulse_eof();
        idle(2);
        exp_wdata[2*DSIZE +: DSIZE] = 16'h0304;
        w0 = (wr_log.size() > 0) ? wr_log[0] : 32'h0;
        vectors++; if (w0 !== 32'h4 || wr_log.size() != 1) begin miscompares++; $display("FAIL wrap_wr_en got %h (n=%0d) exp 00000004", w0, wr_log.size()); end
        vectors++; if (err_cnt != 1) begin miscompares++; $display("FAIL wrap_err got %0d exp 1", err_cnt); end
        vectors++; if (cfg_wdata !== exp_wdata) begin miscompares++; $display("FAIL wrap_wdata got %h exp %h", cfg_wdata, exp_wdata); end
    endtask

    task automatic test_abort();
        logic [31:0] w0;
        clear_logs();
        pulse_sof();
        send_byte(8'h80); send_byte(8'h12); send_byte(8'hAB);
        pulse_eof();
        idle(3);
        vectors++; if (wr_log.size() != 0) begin miscompares++; $display("FAIL abort_pulses got %0d exp 0", wr_log.size()); end
        vectors++; if (cfg_wdata !== exp_wdata) begin miscompares++; $display("FAIL abort_wdata got %h exp %h", cfg_wdata, exp_wdata); end

        clear_logs();
        pulse_sof();
        send_byte(8'h80); send_byte(8'h12); send_byte(8'h55); send_byte(8'h66);
        idle(4);
        pulse_eof();
        idle(2);
        exp_wdata[3*DSIZE +: DSIZE] = 16'h5566;
        w0 = (wr_log.size() > 0) ? wr_log[0] : 32'h0;
        vectors++; if (w0 !== 32'h8) begin miscompares++; $display("FAIL after_abort_wr_en got %h exp 00000008", w0); end
        vectors++; if (cfg_wdata !== exp_wdata) begin miscompares++; $display("FAIL after_abort_wdata got %h exp %h", cfg_wdata, exp_wdata); end

        clear_logs();
        pulse_sof();
        send_byte(8'h80);
        pulse_sof();
        send_byte(8'h80); send_byte(8'h21); send_byte(8'h77); send_byte(8'h88);
        idle(4);
        pulse_eof();
        idle(2);
        exp_wdata[1*DSIZE +: DSIZE] = 16'h7788;
        w0 = (wr_log.size() > 0) ? wr_log[0] : 32'h0;
        vectors++; if (w0 !== 32'h2 || wr_log.size() != 1) begin miscompares++; $display("FAIL restart_wr_en got %h (n=%0d) exp 00000002", w0, wr_log.size()); end
        vectors++; if (cfg_wdata !== exp_wdata) begin miscompares++; $display("FAIL restart_wdata got %h exp %h", cfg_wdata, exp_wdata); end
        vectors++; if (err_cnt != 0) begin miscompares++; $display("FAIL restart_err got %0d exp 0", err_cnt); end
    endtask

    task automatic test_backpressure_reset();
        logic to;
        logic [7:0] b0;
        clear_logs();
        tx_empty = 1'b0;
        pulse_sof();
        send_byte(8'h01); send_byte(8'h00);
        idle(10);
        vectors++; if (tx_log.size() != 0) begin miscompares++; $display("FAIL bp_hold got %0d strobes exp 0", tx_log.size()); end
        tx_empty = 1'b1;
        wait_tx(1, 20, to);
        b0 = (tx_log.size() > 0) ? tx_log[0] : 8'hXX;
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL bp_timeout got %0d strobes exp 1", tx_log.size()); end
        vectors++; if (b0 !== 8'h12) begin miscompares++; $display("FAIL bp_byte0 got %h exp 12", b0); end
        vectors++; if (tx_send_valid !== 1'b1) begin miscompares++; $display("FAIL bp_strobe_live got %b exp 1", tx_send_valid); end
        rst = 1'b1;
        #1;
        vectors++; if (tx_send_valid !== 1'b0) begin miscompares++; $display("FAIL rst_tx_valid got %b exp 0", tx_send_valid); end
        vectors++; if (tx_send_data !== 8'h00) begin miscompares++; $display("FAIL rst_tx_data got %h exp 00", tx_send_data); end
        vectors++; if (cfg_wdata !== '0) begin miscompares++; $display("FAIL rst_wdata got %h exp 0", cfg_wdata); end
        vectors++; if (cfg_wr_en !== '0 || addr_err !== 1'b0) begin miscompares++; $display("FAIL rst_strobes got %h/%b exp 0/0", cfg_wr_en, addr_err); end
        exp_wdata = '0;
        @(negedge clock);
        rst = 1'b0;
        clear_logs();
        idle(10);
        vectors++; if (tx_log.size() != 0) begin miscompares++; $display("FAIL rst_abandon got %0d strobes exp 0", tx_log.size()); end
    endtask

    initial begin
        for (int k = 0; k < NUM; k++) begin
            cfg_addr_map[k*ASIZE +: ASIZE] = 15'h0400 + 15'(k);
            cfg_rdata[k*DSIZE +: DSIZE]    = 16'hA000 + 16'(k);
        end
        cfg_addr_map[0*ASIZE +: ASIZE] = 15'h0020;
        cfg_addr_map[1*ASIZE +: ASIZE] = 15'h0021;
        cfg_addr_map[2*ASIZE +: ASIZE] = 15'h0000;
        cfg_addr_map[3*ASIZE +: ASIZE] = 15'h0012;
        cfg_addr_map[5*ASIZE +: ASIZE] = 15'h0100;
        cfg_addr_map[7*ASIZE +: ASIZE] = 15'h0012;
        cfg_rdata[5*DSIZE +: DSIZE]    = 16'h1234;

        @(negedge clock);
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_miss();
        test_wrap();
        test_abort();
        test_backpressure_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
